// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output receive path.
//   DIN_W/DOUT_W : filter input / output sample widths
//   TAPS         : filter length (sets the default warm-up)
//   fsm_state_e  : receiver FSM encoding, exported on the state port
package fir_pkg;
  localparam int DIN_W  = 10;
  localparam int DOUT_W = 11;
  localparam int TAPS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } fsm_state_e;
endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO with occupancy count.
//   push/din    : write request and data (ignored when full unless popping)
//   pop         : read request (ignored when empty)
//   dout/valid  : head entry, valid while not empty
//   full/cnt    : full flag and occupancy 0..DEPTH
// Pointers carry one extra wrap bit so full (cnt==DEPTH) and empty (cnt==0)
// stay distinct when the indices are equal.
module fir_out_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic                      do_push, do_pop;

  assign cnt     = wr_q - rd_q;
  assign valid   = (cnt != '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  // Pop only a real entry; a push into a full FIFO is accepted only when
  // the head leaves in the same cycle.
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (do_pop) rd_d = rd_q + (AW+1)'(1);
  end

  // Storage is cleared on reset so dout reads 0 until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/fir_out_rx.sv
// Receives the FIR output stream, drops the warm-up samples, decimates by
// DEC and buffers the kept samples in an FWFT FIFO toward a ready/valid sink.
//   clk, rst (async, active low)
//   en        : run enable; dropping it returns the FSM to IDLE
//   fir_dout  : filter output, one sample per cycle
//   m_data/m_valid/m_ready : output stream (FIFO head)
//   fifo_cnt  : FIFO occupancy
//   ovf/clr_ovf : sticky drop flag and its synchronous clear
//   state     : FSM state (IDLE/WARM/RUN)
module fir_out_rx
  import fir_pkg::*;
#(
  parameter int DEC    = 4,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DOUT_W-1:0] fir_dout,
  input  logic              m_ready,
  input  logic              clr_ovf,
  output logic [DOUT_W-1:0] m_data,
  output logic              m_valid,
  output logic [4:0]        fifo_cnt,
  output logic              ovf,
  output logic [1:0]        state
);
  localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
  localparam int AW = $clog2(DEPTH);

  fsm_state_e    state_q;
  logic [WW-1:0] warm_q;
  logic [PW-1:0] phase_q;
  logic          ovf_q, ovf_d;
  logic          push, pop, full, drop;
  logic [AW:0]   cnt;

  // The IDLE cycle that sees en=1 is the first counted warm-up cycle, so
  // WARM lasts WARMUP-1 cycles and RUN starts exactly WARMUP cycles after en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
      phase_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          phase_q <= '0;
          if (en) begin
            if (WARMUP <= 1) begin
              state_q <= ST_RUN;
              warm_q  <= '0;
            end else begin
              state_q <= ST_WARM;
              warm_q  <= WW'(1);
            end
          end
        end
        ST_WARM: begin
          if (!en) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
          end else if (warm_q == WW'(WARMUP - 1)) begin
            state_q <= ST_RUN;
            warm_q  <= '0;
            phase_q <= '0;
          end else begin
            warm_q  <= warm_q + WW'(1);
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
          end else begin
            phase_q <= (phase_q == PW'(DEC - 1)) ? '0 : phase_q + PW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          warm_q  <= '0;
          phase_q <= '0;
        end
      endcase
    end
  end

  assign push = (state_q == ST_RUN) && en && (phase_q == '0);
  assign pop  = m_valid && m_ready;
  assign drop = push && full && !pop;

  // Setting wins over clearing so a drop in a clear cycle is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  fir_out_fifo #(
    .DEPTH (DEPTH),
    .W     (DOUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fir_dout),
    .pop   (pop),
    .dout  (m_data),
    .valid (m_valid),
    .full  (full),
    .cnt   (cnt)
  );

  assign fifo_cnt = 5'(cnt);
  assign ovf      = ovf_q;
  assign state    = state_q;
endmodule

// File: tb/tb_fir_out_rx.sv
module tb_fir_out_rx;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 17;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, m_ready = 1'b0, clr_ovf = 1'b0;
  logic [10:0] fir_dout = '0;

  logic [10:0] m_data0, m_data1;
  logic        m_valid0, m_valid1, ovf0, ovf1;
  logic [4:0]  fifo_cnt0, fifo_cnt1;
  logic [1:0]  state0, state1;

  // Both DUTs see the same stimulus; sel picks the one being checked.
  fir_out_rx #(.DEC(4), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut0 (
    .clk(clk), .rst(rst), .en(en), .fir_dout(fir_dout), .m_ready(m_ready),
    .clr_ovf(clr_ovf), .m_data(m_data0), .m_valid(m_valid0),
    .fifo_cnt(fifo_cnt0), .ovf(ovf0), .state(state0));

  fir_out_rx #(.DEC(1), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut1 (
    .clk(clk), .rst(rst), .en(en), .fir_dout(fir_dout), .m_ready(m_ready),
    .clr_ovf(clr_ovf), .m_data(m_data1), .m_valid(m_valid1),
    .fifo_cnt(fifo_cnt1), .ovf(ovf1), .state(state1));

  always #5 clk = ~clk;

  bit          sel = 1'b0;
  logic [10:0] o_data;
  logic        o_valid, o_ovf;
  logic [4:0]  o_cnt;
  logic [1:0]  o_state;
  always_comb begin
    o_data  = sel ? m_data1   : m_data0;
    o_valid = sel ? m_valid1  : m_valid0;
    o_ovf   = sel ? ovf1      : ovf0;
    o_cnt   = sel ? fifo_cnt1 : fifo_cnt0;
    o_state = sel ? state1    : state0;
  end

  int n_assert = 0, n_fail = 0;

  // Reference model: en-run length, a sample queue and the sticky flag.
  int          mdec = 4;
  int          ecnt = 0;
  int          cidx = 0;
  logic        movf = 1'b0;
  logic [10:0] mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit will_push();
    return en && (ecnt >= WARMUP) && (((ecnt - WARMUP) % mdec) == 0);
  endfunction

  function automatic int exp_state();
    if (ecnt == 0)     return 0;
    if (ecnt < WARMUP) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    mq.delete();
    movf = 1'b0;
    ecnt = 0;
  endtask

  task automatic model_check();
    chk("state", 32'(o_state), 32'(exp_state()));
    chk("fifo_cnt", 32'(o_cnt), 32'(mq.size()));
    chk("m_valid", 32'(o_valid), 32'(mq.size() != 0));
    chk("ovf", 32'(o_ovf), 32'(movf));
    if (mq.size() != 0) chk("m_data", 32'(o_data), 32'(mq[0]));
  endtask

  // One clock: predict from the pre-edge inputs, then sample 1 ns after.
  task automatic cyc();
    bit p, q, d;
    p = will_push();
    q = (mq.size() != 0) && m_ready;
    d = p && (mq.size() == DEPTH) && !q;
    @(posedge clk);
    #1;
    if (q) void'(mq.pop_front());
    if (p && !d) mq.push_back(fir_dout);
    if (clr_ovf) movf = 1'b0;
    if (d) movf = 1'b1;
    ecnt = en ? ecnt + 1 : 0;
    cidx++;
    model_check();
  endtask

  initial begin
    int n;
    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state0", 32'(state0), 0);
    chk("rst_cnt0", 32'(fifo_cnt0), 0);
    chk("rst_valid0", 32'(m_valid0), 0);
    chk("rst_data0", 32'(m_data0), 0);
    chk("rst_ovf0", 32'(ovf0), 0);
    chk("rst_state1", 32'(state1), 0);
    chk("rst_data1", 32'(m_data1), 0);
    rst = 1'b1;
    model_reset();

    // V1: warm-up of 17, then one push every 4 cycles.
    en = 1'b1; m_ready = 1'b1; cidx = 0;
    for (int i = 0; i < 30; i++) begin
      fir_dout = 11'(cidx);
      cyc();
      if (cidx == 17) chk("v1_no_push", 32'(fifo_cnt0), 0);
      if (cidx == 18) chk("v1_first", 32'(m_data0), 17);
      if (cidx == 22) chk("v1_second", 32'(m_data0), 21);
      if (cidx == 26) chk("v1_third", 32'(m_data0), 25);
    end

    // V4: en gap in RUN; FIFO kept, warm-up repeats.
    m_ready = 1'b0;
    for (int i = 0; i < 40 && mq.size() < 3; i++) begin
      fir_dout = 11'($urandom); cyc();
    end
    n = mq.size();
    en = 1'b0;
    repeat (3) cyc();
    chk("v4_kept", 32'(fifo_cnt0), 32'(n));
    chk("v4_idle", 32'(state0), 0);
    en = 1'b1;
    repeat (16) begin fir_dout = 11'($urandom); cyc(); end
    chk("v4_warm", 32'(state0), 1);
    chk("v4_kept2", 32'(fifo_cnt0), 32'(n));
    fir_dout = 11'($urandom); cyc();
    chk("v4_run", 32'(state0), 2);

    // Fill to full.
    for (int i = 0; i < 100 && mq.size() < DEPTH; i++) begin
      fir_dout = 11'($urandom); cyc();
    end
    chk("full", 32'(fifo_cnt0), DEPTH);
    for (int i = 0; i < 8 && will_push(); i++) cyc();
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    chk("ovf_clear", 32'(ovf0), 0);

    // V6: overflow drop and clear in the same cycle, then clear alone.
    for (int i = 0; i < 8 && !will_push(); i++) cyc();
    if (!will_push()) chk("v6_timeout", 0, 1);
    fir_dout = 11'($urandom);
    clr_ovf = 1'b1; cyc();
    chk("v6_set_wins", 32'(ovf0), 1);
    chk("v6_cnt", 32'(fifo_cnt0), DEPTH);
    cyc(); clr_ovf = 1'b0;
    chk("v6_cleared", 32'(ovf0), 0);

    // V3: full, push and pop together.
    for (int i = 0; i < 8 && !will_push(); i++) cyc();
    if (!will_push()) chk("v3_timeout", 0, 1);
    fir_dout = 11'($urandom);
    m_ready = 1'b1; cyc();
    chk("v3_cnt", 32'(fifo_cnt0), DEPTH);
    chk("v3_ovf", 32'(ovf0), 0);
    en = 1'b0;
    repeat (10) cyc();
    chk("v3_drained", 32'(m_valid0), 0);

    // Random traffic on DEC=4.
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 19) != 0);
      m_ready  = ($urandom_range(0, 1) != 0);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      fir_dout = 11'($urandom);
      cyc();
    end
    clr_ovf = 1'b0;

    // V5: async reset with 5 entries.
    en = 1'b0; m_ready = 1'b1;
    repeat (10) cyc();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 100 && mq.size() < 5; i++) begin
      fir_dout = 11'($urandom); cyc();
    end
    chk("v5_pre", 32'(fifo_cnt0), 5);
    en = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("v5_valid", 32'(m_valid0), 0);
    chk("v5_cnt", 32'(fifo_cnt0), 0);
    chk("v5_state", 32'(state0), 0);
    chk("v5_data", 32'(m_data0), 0);
    model_reset();

    // V2 on DEC=1: saturate at 8, overflow on the 9th push.
    sel = 1'b1; mdec = 1;
    @(posedge clk);
    #1 rst = 1'b1;
    en = 1'b1; m_ready = 1'b0; cidx = 0;
    for (int i = 0; i < 27; i++) begin
      fir_dout = 11'(cidx);
      cyc();
      if (cidx == 25) begin
        chk("v2_sat", 32'(fifo_cnt1), 8);
        chk("v2_no_ovf", 32'(ovf1), 0);
      end
      if (cidx == 26) begin
        chk("v2_ovf", 32'(ovf1), 1);
        chk("v2_cnt", 32'(fifo_cnt1), 8);
      end
    end
    en = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("v2_data", 32'(m_data1), 32'(17 + k));
      cyc();
    end

    // Random traffic on DEC=1.
    for (int i = 0; i < 200; i++) begin
      en       = ($urandom_range(0, 15) != 0);
      m_ready  = ($urandom_range(0, 2) == 0);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      fir_dout = 11'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
